// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage RV32 pipeline.
//
// Holds the pipeline frozen (stalled and flushed) after reset until trigger_i
// is seen. After that it runs until the next reset and provides:
// - E-stage operand forwarding selects
// - a load-use stall of the PC and D registers, with a bubble injected into E
// - a control-flush of D and E when a jump or branch is taken
//
// Optional feature macro: HAZARD_CTRL_PERF_CNT_EN
//   When defined, two saturating debug counters are built: load-use stall
//   cycles and control-flush events. When undefined, both counter outputs
//   read zero and no counter registers exist.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   trigger_i                    start request, only looked at while waiting
//   Rs1D_i, Rs2D_i               source registers of the instruction in Decode
//   Rs1E_i, Rs2E_i, RdE_i        source and destination registers in Execute
//   RdM_i, RegWriteM_i           destination register and write enable in Memory
//   RdW_i, RegWriteW_i           destination register and write enable in Writeback
//   ResultSrcE_i                 result select in Execute (2'b01 = load)
//   PCSrcE_i                     taken jump/branch resolved in Execute
//   ForwardAE_o, ForwardBE_o     00 register file, 01 ResultW, 10 ALUResultM
//   StallF_o, StallD_o           hold the PC register and the D register
//   FlushD_o, FlushE_o           clear the D and E registers on the next edge
//   running_o                    registered: controller is running
//   stall_cnt_o, flush_cnt_o     saturating debug counters
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      trigger_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      RegWriteM_i,
  input  logic                      RegWriteW_i,
  input  logic [1:0]                ResultSrcE_i,
  input  logic                      PCSrcE_i,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o,
  output logic                      StallF_o,
  output logic                      StallD_o,
  output logic                      FlushD_o,
  output logic                      FlushE_o,
  output logic                      running_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  typedef enum logic [0:0] {StWait, StRun} state_e;

  state_e state_q, state_d;
  logic   lw_stall;

  // The Memory stage holds the younger result, so it is checked first.
  // x0 is never forwarded since it always reads as zero.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                         input logic [REG_ADDR_WIDTH-1:0] rd_m,
                                         input logic                      we_m,
                                         input logic [REG_ADDR_WIDTH-1:0] rd_w,
                                         input logic                      we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0 && rs == rd_m && we_m) begin
      sel = 2'b10;
    end else if (rs != '0 && rs == rd_w && we_w) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign lw_stall = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                    ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));

  always_comb begin
    state_d     = state_q;
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    unique case (state_q)
      StWait: begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
        if (trigger_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        ForwardAE_o = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
        ForwardBE_o = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
        // A taken branch squashes the instruction in Decode, so the load-use
        // stall it would have caused is moot: flush takes priority.
        if (PCSrcE_i) begin
          FlushD_o = 1'b1;
          FlushE_o = 1'b1;
        end else if (lw_stall) begin
          StallF_o = 1'b1;
          StallD_o = 1'b1;
          FlushE_o = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  assign running_o = (state_q == StRun);

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic                 stall_evt, flush_evt;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  assign stall_evt = (state_q == StRun) && lw_stall && !PCSrcE_i;
  assign flush_evt = (state_q == StRun) && PCSrcE_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (flush_evt && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam int CntMax = (1 << CW) - 1;
`ifdef HAZARD_CTRL_PERF_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          trigger;
  logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic          regwritem, regwritew;
  logic [1:0]    resultsrce;
  logic          pcsrce;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall_f, stall_d, flush_d, flush_e, running;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(
    .REG_ADDR_WIDTH(AW),
    .CNT_WIDTH     (CW)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .trigger_i   (trigger),
    .Rs1D_i      (rs1d),
    .Rs2D_i      (rs2d),
    .Rs1E_i      (rs1e),
    .Rs2E_i      (rs2e),
    .RdE_i       (rde),
    .RdM_i       (rdm),
    .RdW_i       (rdw),
    .RegWriteM_i (regwritem),
    .RegWriteW_i (regwritew),
    .ResultSrcE_i(resultsrce),
    .PCSrcE_i    (pcsrce),
    .ForwardAE_o (fwd_a),
    .ForwardBE_o (fwd_b),
    .StallF_o    (stall_f),
    .StallD_o    (stall_d),
    .FlushD_o    (flush_d),
    .FlushE_o    (flush_e),
    .running_o   (running),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_run;
  int m_stall_cnt;
  int m_flush_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input int rs);
    if (rs == 0) return 0;
    if (rs == int'(rdm) && regwritem) return 2;
    if (rs == int'(rdw) && regwritew) return 1;
    return 0;
  endfunction

  function automatic bit exp_lw();
    return resultsrce == 2'b01 && rde != 0 && (rs1d == rde || rs2d == rde);
  endfunction

  // Compare every output with the model in the middle of the cycle.
  task automatic check_all();
    bit lw, br;
    int ef, es, efd, efe, fa, fb;
    lw = exp_lw();
    br = pcsrce;
    if (!m_run) begin
      ef = 1; es = 1; efd = 1; efe = 1; fa = 0; fb = 0;
    end else begin
      fa  = exp_fwd(int'(rs1e));
      fb  = exp_fwd(int'(rs2e));
      ef  = (lw && !br) ? 1 : 0;
      es  = ef;
      efd = br ? 1 : 0;
      efe = (br || lw) ? 1 : 0;
    end
    check("ForwardAE", int'(fwd_a), fa);
    check("ForwardBE", int'(fwd_b), fb);
    check("StallF", int'(stall_f), ef);
    check("StallD", int'(stall_d), es);
    check("FlushD", int'(flush_d), efd);
    check("FlushE", int'(flush_e), efe);
    check("running", int'(running), int'(m_run));
    check("stall_cnt", int'(stall_cnt), m_stall_cnt);
    check("flush_cnt", int'(flush_cnt), m_flush_cnt);
  endtask

  task automatic model_edge();
    bit lw;
    lw = exp_lw();
    if (rst) begin
      m_run = 1'b0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else if (!m_run) begin
      if (trigger) m_run = 1'b1;
    end else if (CntEn) begin
      if (pcsrce) m_flush_cnt = (m_flush_cnt < CntMax) ? m_flush_cnt + 1 : CntMax;
      else if (lw) m_stall_cnt = (m_stall_cnt < CntMax) ? m_stall_cnt + 1 : CntMax;
    end
  endtask

  // Inputs are already applied; check mid-cycle, then advance past the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; trigger = 0;
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    regwritem = 0; regwritew = 0; resultsrce = 0; pcsrce = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    m_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;  // first edge puts both DUT and model into reset
    cycle();
    rst = 0;

    // 1: wait frozen, then trigger
    for (int i = 0; i < 10; i++) cycle();
    trigger = 1;
    cycle();
    trigger = 0;
    cycle();
    check("t1_running", int'(running), 1);

    // 2: forwarding priority, A then B
    rs1e = 5; rdm = 5; regwritem = 1; rdw = 5; regwritew = 1;
    #1 check("t2_fwdA_M", int'(fwd_a), 2);
    cycle();
    regwritem = 0;
    #1 check("t2_fwdA_W", int'(fwd_a), 1);
    cycle();
    rs1e = 0; regwritem = 1;
    #1 check("t2_fwdA_x0", int'(fwd_a), 0);
    cycle();
    rs2e = 5;
    #1 check("t2_fwdB_M", int'(fwd_b), 2);
    cycle();
    regwritem = 0;
    #1 check("t2_fwdB_W", int'(fwd_b), 1);
    cycle();
    rs2e = 0;
    cycle();
    idle_inputs();

    // 3: load-use stall, then rd = x0 gives none
    resultsrce = 2'b01; rde = 7; rs2d = 7;
    #1 check("t3_stallF", int'(stall_f), 1);
    cycle();
    check("t3_stall_cnt", int'(stall_cnt), CntEn ? 1 : 0);
    rde = 0; rs2d = 0;
    #1 check("t3_x0_nostall", int'(stall_f), 0);
    cycle();

    // 4: branch and load-use together
    resultsrce = 2'b01; rde = 7; rs2d = 7; pcsrce = 1;
    #1 check("t4_stallF", int'(stall_f), 0);
    cycle();
    check("t4_flush_cnt", int'(flush_cnt), CntEn ? 1 : 0);
    check("t4_stall_cnt", int'(stall_cnt), CntEn ? 1 : 0);
    pcsrce = 0;

    // 5: saturate the stall counter, then reset
    for (int i = 0; i < 20; i++) cycle();
    check("t5_sat", int'(stall_cnt), CntEn ? CntMax : 0);
    do_reset();
    check("t5_rst_cnt", int'(stall_cnt), 0);
    check("t5_rst_run", int'(running), 0);

    // Random traffic with occasional reset and trigger
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      trigger    = ($urandom_range(0, 7) == 0);
      rs1d       = AW'($urandom_range(0, 7));
      rs2d       = AW'($urandom_range(0, 7));
      rs1e       = AW'($urandom_range(0, 7));
      rs2e       = AW'($urandom_range(0, 7));
      rde        = AW'($urandom_range(0, 7));
      rdm        = AW'($urandom_range(0, 7));
      rdw        = AW'($urandom_range(0, 7));
      regwritem  = 1'($urandom_range(0, 1));
      regwritew  = 1'($urandom_range(0, 1));
      resultsrce = 2'($urandom_range(0, 3));
      pcsrce     = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
